// File: rtl/serial_sub_ctrl_pkg.sv
// Shared arithmetic package for the serial subtractor.
// Holds the nibble width and the controller state encoding, so the
// datapath, the controller and any checker agree on both.
package serial_sub_ctrl_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sub4_cin.sv
// 4-bit subtract-with-borrow datapath.
// Ports:
//   I0  - minuend nibble
//   I1  - subtrahend nibble
//   CIN - borrow in (active high)
//   O   - I0 + ~I1 + ~CIN, i.e. I0 - I1 - CIN modulo 16
// There is no carry-out; the caller derives the nibble borrow itself.
module sub4_cin
  import serial_sub_ctrl_pkg::*;
(
  input  logic [NIB_W-1:0] I0,
  input  logic [NIB_W-1:0] I1,
  input  logic             CIN,
  output logic [NIB_W-1:0] O
);

  assign O = I0 + ~I1 + {{(NIB_W-1){1'b0}}, ~CIN};

endmodule

// File: rtl/serial_sub_ctrl.sv
// Serial multi-nibble subtractor controller.
// Computes O = I0 - I1 - BIN one nibble per cycle, LSB nibble first,
// through a single shared sub4_cin datapath.
//
// Handshake: a transfer happens on a rising CLK edge where the sender's
// VALID and the receiver's READY are both 1. IN_READY is 1 only in IDLE,
// OUT_VALID is 1 only in DONE; a result is consumed on a DONE edge with
// OUT_READY=1, and that same edge never accepts new operands.
//
// Ports:
//   CLK, RESET         - clock, synchronous active-high reset
//   I0, I1, BIN        - minuend, subtrahend, borrow-in
//   IN_VALID/IN_READY  - operand handshake
//   O, BOUT            - difference and final borrow-out
//   OUT_VALID/OUT_READY- result handshake
//   dbg_state          - current controller state for observation
module serial_sub_ctrl
  import serial_sub_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [NIBBLES*NIB_W-1:0] I0,
  input  logic [NIBBLES*NIB_W-1:0] I1,
  input  logic                     BIN,
  input  logic                     IN_VALID,
  output logic                     IN_READY,
  output logic [NIBBLES*NIB_W-1:0] O,
  output logic                     BOUT,
  output logic                     OUT_VALID,
  input  logic                     OUT_READY,
  output state_t                   dbg_state
);

  state_t                   state, state_nxt;
  // One-hot nibble index: bit k set means nibble k is being processed.
  // Shifting avoids an incrementer and makes saturation trivial.
  logic [NIBBLES-1:0]       idx_oh;
  logic                     borrow;
  logic [NIBBLES*NIB_W-1:0] op0, op1, o_reg;
  logic                     bout_reg;

  logic [NIB_W-1:0]         nib_a, nib_b, nib_o;
  logic                     nib_bout;

  // Select the active nibble of the captured operands.
  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int k = 0; k < NIBBLES; k++) begin
      if (idx_oh[k]) begin
        nib_a = op0[k*NIB_W +: NIB_W];
        nib_b = op1[k*NIB_W +: NIB_W];
      end
    end
  end

  sub4_cin u_sub4 (
    .I0  (nib_a),
    .I1  (nib_b),
    .CIN (borrow),
    .O   (nib_o)
  );

  // Datapath has no carry-out, so borrow is an explicit 5-bit compare.
  assign nib_bout = ({1'b0, nib_a} < ({1'b0, nib_b} + {{NIB_W{1'b0}}, borrow}));

  always_comb begin
    state_nxt = state;
    IN_READY  = 1'b0;
    OUT_VALID = 1'b0;
    case (state)
      IDLE: begin
        IN_READY = 1'b1;
        if (IN_VALID) state_nxt = RUN;
      end
      RUN: begin
        if (idx_oh[NIBBLES-1]) state_nxt = DONE;
      end
      DONE: begin
        OUT_VALID = 1'b1;
        if (OUT_READY) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      idx_oh   <= NIBBLES'(1);
      borrow   <= 1'b0;
      op0      <= '0;
      op1      <= '0;
      o_reg    <= '0;
      bout_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (IN_VALID) begin
            op0    <= I0;
            op1    <= I1;
            borrow <= BIN;
            idx_oh <= NIBBLES'(1);
          end
        end
        RUN: begin
          for (int k = 0; k < NIBBLES; k++) begin
            if (idx_oh[k]) o_reg[k*NIB_W +: NIB_W] <= nib_o;
          end
          borrow <= nib_bout;
          if (idx_oh[NIBBLES-1]) bout_reg <= nib_bout;
          else                   idx_oh   <= idx_oh << 1;
        end
        default: ;
      endcase
    end
  end

  assign O         = o_reg;
  assign BOUT      = bout_reg;
  assign dbg_state = state;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
module tb_serial_sub_ctrl;
  import serial_sub_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst, bin, in_valid, out_ready;
  wire  [2:0] in_ready, out_valid, bout;
  logic [2:0] rand_ready;

  // unit 0: NIBBLES=4, unit 1: NIBBLES=2, unit 2: NIBBLES=8
  logic [15:0] a4, b4;
  logic [7:0]  a2, b2;
  logic [31:0] a8, b8;
  wire  [15:0] o4;
  wire  [7:0]  o2;
  wire  [31:0] o8;
  state_t st0, st1, st2;

  serial_sub_ctrl #(.NIBBLES(4)) dut4 (
    .CLK(clk), .RESET(rst[0]), .I0(a4), .I1(b4), .BIN(bin[0]),
    .IN_VALID(in_valid[0]), .IN_READY(in_ready[0]), .O(o4), .BOUT(bout[0]),
    .OUT_VALID(out_valid[0]), .OUT_READY(out_ready[0]), .dbg_state(st0));

  serial_sub_ctrl #(.NIBBLES(2)) dut2 (
    .CLK(clk), .RESET(rst[1]), .I0(a2), .I1(b2), .BIN(bin[1]),
    .IN_VALID(in_valid[1]), .IN_READY(in_ready[1]), .O(o2), .BOUT(bout[1]),
    .OUT_VALID(out_valid[1]), .OUT_READY(out_ready[1]), .dbg_state(st1));

  serial_sub_ctrl #(.NIBBLES(8)) dut8 (
    .CLK(clk), .RESET(rst[2]), .I0(a8), .I1(b8), .BIN(bin[2]),
    .IN_VALID(in_valid[2]), .IN_READY(in_ready[2]), .O(o8), .BOUT(bout[2]),
    .OUT_VALID(out_valid[2]), .OUT_READY(out_ready[2]), .dbg_state(st2));

  // ---------------- scoreboard state ----------------
  logic [32:0] exp_q0[$];
  logic [32:0] exp_q1[$];
  logic [32:0] exp_q2[$];
  int n_tests = 0;
  int n_fail  = 0;
  int n_sent[3];
  int n_recv[3];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int width(input int u);
    case (u)
      0:       return 16;
      1:       return 8;
      default: return 32;
    endcase
  endfunction

  // Reference: plain unsigned arithmetic on the full operand width.
  function automatic logic [32:0] model(input int u, input logic [31:0] a,
                                        input logic [31:0] b, input logic bi);
    longint unsigned m  = (64'd1 << width(u)) - 64'd1;
    longint unsigned da = {32'd0, a} & m;
    longint unsigned db = {32'd0, b} & m;
    longint unsigned d  = (da - db - {63'd0, bi}) & m;
    logic bo = (da < (db + {63'd0, bi}));
    return {bo, d[31:0]};
  endfunction

  function automatic logic [31:0] get_o(input int u);
    case (u)
      0:       return {16'd0, o4};
      1:       return {24'd0, o2};
      default: return o8;
    endcase
  endfunction

  function automatic int q_size(input int u);
    case (u)
      0:       return exp_q0.size();
      1:       return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  function automatic logic [32:0] q_front(input int u);
    case (u)
      0:       return exp_q0[0];
      1:       return exp_q1[0];
      default: return exp_q2[0];
    endcase
  endfunction

  task automatic q_push(input int u, input logic [32:0] v);
    case (u)
      0:       exp_q0.push_back(v);
      1:       exp_q1.push_back(v);
      default: exp_q2.push_back(v);
    endcase
    n_sent[u]++;
  endtask

  task automatic q_pop(input int u);
    case (u)
      0:       void'(exp_q0.pop_front());
      1:       void'(exp_q1.pop_front());
      default: void'(exp_q2.pop_front());
    endcase
    n_recv[u]++;
  endtask

  task automatic set_ops(input int u, input logic [31:0] a, input logic [31:0] b);
    case (u)
      0:       begin a4 = a[15:0]; b4 = b[15:0]; end
      1:       begin a2 = a[7:0];  b2 = b[7:0];  end
      default: begin a8 = a;       b8 = b;       end
    endcase
  endtask

  // ---------------- driver ----------------
  // Called at #1 after a rising edge; returns at #1 after the accepting edge.
  task automatic issue(input int u, input logic [31:0] a, input logic [31:0] b,
                       input logic bi);
    set_ops(u, a, b);
    bin[u]      = bi;
    in_valid[u] = 1'b1;
    for (int c = 0; c < 300; c++) begin
      if (in_ready[u]) begin
        q_push(u, model(u, a, b, bi));
        @(posedge clk); #1;
        in_valid[u] = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    in_valid[u] = 1'b0;
    chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    int c = 0;
    while ((q_size(0) + q_size(1) + q_size(2)) != 0 && c < 4000) begin
      @(posedge clk);
      c++;
    end
    #1;
    if (c >= 4000) chk("drain_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_random(input int u, input int n);
    for (int t = 0; t < n; t++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 7) == 0) b = a;
      issue(u, a, b, 1'($urandom_range(0, 1)));
      // operands left driven with stale values while the unit is busy
      set_ops(u, $urandom, $urandom);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  // ---------------- monitor ----------------
  task automatic check_unit(input int u);
    logic [32:0] e;
    if (out_valid[u]) begin
      if (q_size(u) == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_output unit %0d: got 0x%0h with nothing expected", u, get_o(u));
      end else begin
        e = q_front(u);
        chk($sformatf("result_o_u%0d", u), {32'd0, get_o(u)}, {32'd0, e[31:0]});
        chk($sformatf("result_bout_u%0d", u), {63'd0, bout[u]}, {63'd0, e[32]});
        if (out_ready[u]) q_pop(u);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      for (int u = 0; u < 3; u++) check_unit(u);
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      for (int u = 0; u < 3; u++)
        if (rand_ready[u]) out_ready[u] = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [32:0] e;
    int c;
    for (int u = 0; u < 3; u++) begin n_sent[u] = 0; n_recv[u] = 0; end
    rst = 3'b111; bin = '0; in_valid = '0; out_ready = '0; rand_ready = '0;
    a4 = '0; b4 = '0; a2 = '0; b2 = '0; a8 = '0; b8 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", 64'(st0), 64'(IDLE));
    chk("reset_o", {48'd0, o4}, 64'd0);
    chk("reset_bout", {63'd0, bout[0]}, 64'd0);
    chk("reset_out_valid", {63'd0, out_valid[0]}, 64'd0);
    chk("reset_in_ready", {63'd0, in_ready[0]}, 64'd1);
    rst = 3'b000;
    @(posedge clk); #1;

    // latency: OUT_VALID first seen on cycle NIBBLES+1 after accept
    out_ready[0] = 1'b1;
    issue(0, 32'h1234, 32'h0001, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      chk($sformatf("latency_cycle%0d", k), {63'd0, out_valid[0]}, {63'd0, (k == 5)});
      chk("in_ready_busy", {63'd0, in_ready[0]}, 64'd0);
      if (k < 5) begin @(posedge clk); #1; end
    end
    drain();

    // borrow ripple and BIN cases
    issue(0, 32'h0000, 32'h0001, 1'b0);
    issue(0, 32'h1000, 32'h0FFF, 1'b1);
    issue(0, 32'h0000, 32'h0000, 1'b1);
    issue(0, 32'hFFFF, 32'hFFFF, 1'b0);
    drain();

    // hold in DONE with IN_VALID=1 and changing operands
    out_ready[0] = 1'b0;
    e = model(0, 32'h5678, 32'h1234, 1'b0);
    issue(0, 32'h5678, 32'h1234, 1'b0);
    c = 0;
    while (!out_valid[0] && c < 50) begin @(posedge clk); #1; c++; end
    chk("done_reached", {63'd0, out_valid[0]}, 64'd1);
    for (int k = 0; k < 10; k++) begin
      in_valid[0] = 1'b1;
      set_ops(0, $urandom, $urandom);
      bin[0] = 1'($urandom_range(0, 1));
      chk("hold_o", {48'd0, o4}, {48'd0, e[15:0]});
      chk("hold_bout", {63'd0, bout[0]}, {63'd0, e[32]});
      chk("hold_in_ready", {63'd0, in_ready[0]}, 64'd0);
      @(posedge clk); #1;
    end
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    chk("consume_to_idle", 64'(st0), 64'(IDLE));
    chk("consume_in_ready", {63'd0, in_ready[0]}, 64'd1);
    chk("consume_out_valid", {63'd0, out_valid[0]}, 64'd0);
    in_valid[0] = 1'b0;
    @(posedge clk); #1;

    // reset while processing nibble index 2
    issue(0, 32'h1111, 32'h0101, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst[0] = 1'b1;
    @(posedge clk); #1;
    chk("midrun_reset_state", 64'(st0), 64'(IDLE));
    chk("midrun_reset_o", {48'd0, o4}, 64'd0);
    chk("midrun_reset_out_valid", {63'd0, out_valid[0]}, 64'd0);
    chk("midrun_reset_bout", {63'd0, bout[0]}, 64'd0);
    rst[0] = 1'b0;
    exp_q0.delete();
    n_sent[0]--;
    issue(0, 32'h00FF, 32'h000F, 1'b0);
    drain();

    // randomized back-to-back traffic on all three widths
    rand_ready = 3'b111;
    fork
      run_random(0, 40);
      run_random(1, 40);
      run_random(2, 40);
    join
    rand_ready = 3'b000;
    out_ready  = 3'b111;
    drain();
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 3; u++) begin
      chk($sformatf("pending_u%0d", u), 64'(q_size(u)), 64'd0);
      chk($sformatf("count_u%0d", u), 64'(n_recv[u]), 64'(n_sent[u]));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_sub_ctrl.md
SERIAL_SUB_CTRL -- requirements
Module: serial_sub_ctrl

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, number of 4-bit digits per operand (legal range 2..8).
REQ-002 SHALL have port CLK  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-004 SHALL have port I0  input  4*NIBBLES  minuend.
REQ-005 SHALL have port I1  input  4*NIBBLES  subtrahend.
REQ-006 SHALL have port BIN  input  1  borrow-in for the least significant nibble.
REQ-007 SHALL have port IN_VALID  input  1  operands and BIN are valid.
REQ-008 SHALL have port IN_READY  output  1  block can accept operands.
REQ-009 SHALL have port O  output  4*NIBBLES  difference, I0 - I1 - BIN, modulo 2^(4*NIBBLES).
REQ-010 SHALL have port BOUT  output  1  final borrow-out; 1 when I0 < I1 + BIN (unsigned).
REQ-011 SHALL have port OUT_VALID  output  1  O and BOUT are valid.
REQ-012 SHALL have port OUT_READY  input  1  consumer accepts the result.

Function
REQ-013 SHALL compute the full-width difference one nibble per cycle, least significant nibble first, through a single shared 4-bit subtract-with-borrow datapath.
REQ-014 SHALL implement states IDLE, RUN and DONE.
REQ-015 In IDLE: IN_READY=1 and OUT_VALID=0; when IN_VALID=1, SHALL capture I0, I1 and BIN, clear the nibble index to 0, and move to RUN.
REQ-016 In RUN: IN_READY=0 and OUT_VALID=0; each cycle SHALL apply nibble[idx] of I0 and I1 plus the current borrow to the datapath, write the 4-bit result into O nibble[idx], and register the nibble borrow-out as the next borrow.
REQ-017 Nibble borrow-out SHALL equal 1 exactly when a < b + bin, evaluated unsigned at 5-bit width; this is computed in the controller because the datapath has no carry-out.
REQ-018 After the nibble with idx = NIBBLES-1 is written, SHALL move to DONE with BOUT equal to that nibble's borrow-out.
REQ-019 Latency SHALL be exactly NIBBLES+1 cycles from the accepting IDLE edge to the first cycle with OUT_VALID=1.
REQ-020 In DONE: OUT_VALID=1 and IN_READY=0; O and BOUT SHALL stay stable until OUT_READY=1, and on that edge the block SHALL return to IDLE.
REQ-021 The block SHALL NOT accept a new operand on the same edge that a result is consumed; minimum throughput is one result per NIBBLES+2 cycles.
REQ-022 Inputs I0, I1 and BIN SHALL be ignored outside the IDLE accepting edge; changing them during RUN SHALL NOT affect the result.
REQ-023 The nibble index SHALL saturate at NIBBLES-1 and never wrap into an out-of-range nibble.

Reset
REQ-024 RESET=1 at a rising edge SHALL force state IDLE, index 0, borrow 0, O=0, BOUT=0, OUT_VALID=0, and IN_READY=1 on the following cycle.
REQ-025 RESET SHALL override every other input in any state, including mid-RUN and in DONE with OUT_READY=1, and SHALL discard any partial result.
REQ-026 No output SHALL depend combinationally on RESET.

Structure
REQ-027 The state encoding (IDLE/RUN/DONE) and the nibble width constant 4 SHALL live in the shared arithmetic package.
REQ-028 SHALL instantiate exactly one sub-module, sub4_cin (4-bit I0 + ~I1 + ~CIN), as the datapath, with CIN driven by the registered borrow.
REQ-029 The controller SHALL be 120-400 lines of RTL, with no multipliers and no further adders beyond the borrow compare.

Verification
REQ-030 NIBBLES=4: I0=0x1234, I1=0x0001, BIN=0, accept -> OUT_VALID on cycle 5, O=0x1233, BOUT=0.
REQ-031 I0=0x0000, I1=0x0001, BIN=0 -> O=0xFFFF, BOUT=1 (borrow ripples through all nibbles).
REQ-032 I0=0x1000, I1=0x0FFF, BIN=1 -> O=0x0000, BOUT=0; then I0=0x0000, I1=0x0000, BIN=1 -> O=0xFFFF, BOUT=1.
REQ-033 Hold OUT_READY=0 for 10 cycles in DONE with IN_VALID=1 and changing operands -> O and BOUT stable, IN_READY=0; after OUT_READY=1, IDLE on the next cycle.
REQ-034 Assert RESET at RUN index 2 -> the next cycle shows IDLE, O=0, OUT_VALID=0; a fresh 0x00FF - 0x000F returns 0x00F0.
REQ-035 Random back-to-back transactions with random OUT_READY, NIBBLES=2 and NIBBLES=8 -> every result matches a reference model, and no operand is lost or duplicated.
